// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix load path: controller state encoding and
// the byte counts of the supported matrix-pair sizes.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } load_state_t;

    // Each load carries two square matrices of one byte per element.
    localparam int LEN_2X2 = 2 * 2 * 2;
    localparam int LEN_3X3 = 2 * 3 * 3;
    localparam int LEN_4X4 = 2 * 4 * 4;
    localparam int LEN_5X5 = 2 * 5 * 5;
    localparam int MAX_LEN = LEN_5X5;

endpackage

// File: rtl/load_watchdog.sv
// Idle-cycle watchdog for the matrix loader: counts ticks, cleared on demand,
// and flags the tick that completes TIMEOUT_CYCLES consecutive idle cycles.
module load_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_reg <= '0;
        end else if (i_clear) begin
            cnt_reg <= '0;
        end else if (i_tick) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Fires combinationally on the last idle cycle so the owner can leave
    // its waiting state on the same edge.
    assign o_expire = i_tick && !i_clear && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/matrix_load_ctrl.sv
// Matrix load controller: accepts a latched number of bytes from the receive
// stream and emits registered write strobes. Optional watchdog: MATRIX_LOAD_TIMEOUT_EN.
module matrix_load_ctrl
    import matrix_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int LEN_W          = 8,
    parameter int MAX_LEN        = matrix_pkg::MAX_LEN,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_wr_en,
    output logic [LEN_W-1:0]  o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [LEN_W-1:0]  o_count
);

    load_state_t       state_reg, state_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  count_reg, count_next;
    logic [LEN_W-1:0]  count_inc;
    logic              wr_en_reg, wr_en_next;
    logic [LEN_W-1:0]  wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0] wr_data_reg, wr_data_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              rx_ready;
    logic              handshake;
    logic              wd_expire;

    assign rx_ready  = (state_reg == LOAD);
    assign handshake = rx_ready && i_rx_valid;
    assign count_inc = count_reg + 1'b1;

`ifdef MATRIX_LOAD_TIMEOUT_EN
    load_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (!rx_ready || handshake),
        .i_tick    (rx_ready && !handshake),
        .o_expire  (wd_expire)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        count_next   = count_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        done_next    = 1'b0;
        err_next     = err_reg;

        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    len_next   = i_len;
                    count_next = '0;
                    err_next   = 1'b0;
                    if (i_len == '0) begin
                        state_next = DONE;
                    end else if (i_len > LEN_W'(MAX_LEN)) begin
                        state_next = ERR;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (handshake) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = count_reg;
                    wr_data_next = i_rx_data;
                    count_next   = count_inc;
                    // Done is raised alongside the final write strobe.
                    if (count_inc == len_reg) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end else if (wd_expire) begin
                    state_next = ERR;
                end
            end
            DONE: begin
                // Stay until the one-cycle pulse has been shown; a zero-length
                // load arrives here without it and emits it one cycle later.
                done_next = !done_reg;
                if (done_reg) begin
                    state_next = IDLE;
                end
            end
            ERR: begin
                err_next   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            count_reg   <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            count_reg   <= count_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    assign o_rx_ready = rx_ready;
    assign o_wr_en    = wr_en_reg;
    assign o_wr_addr  = wr_addr_reg;
    assign o_wr_data  = wr_data_reg;
    assign o_busy     = (state_reg == LOAD) || (state_reg == DONE);
    assign o_done     = done_reg;
    assign o_err      = err_reg;
    assign o_count    = count_reg;

endmodule

// File: doc/matrix_load_ctrl.md
# matrix_load_ctrl

Downstream consumer of the matrix data-length stage. Takes the computed byte count for the selected matrix type, then accepts exactly that many bytes from the host receive stream and turns each into a registered write strobe, address and data for the matrix write DEMUX/buffer. It signals completion with a one-cycle done pulse, or an error, so the compute engine can start.

## Interface
- DATA_W, 8: width of received bytes and write data
- LEN_W, 8: width of length, count and address
- MAX_LEN, 50: largest legal length (two 5x5 matrices)
- TIMEOUT_CYCLES, 1000000: idle cycles between bytes before abort (used only with the timeout macro)

- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle pulse; latches i_len and begins a load
- i_len  in  LEN_W  byte count from the data-length stage
- i_rx_data  in  DATA_W  received byte
- i_rx_valid  in  1  i_rx_data valid this cycle
- o_rx_ready  out  1  byte accepted when i_rx_valid && o_rx_ready
- o_wr_en  out  1  write strobe to matrix DEMUX
- o_wr_addr  out  LEN_W  element index, 0-based
- o_wr_data  out  DATA_W  element byte
- o_busy  out  1  load in progress
- o_done  out  1  one-cycle pulse, load complete
- o_err  out  1  sticky error, cleared by next i_start
- o_count  out  LEN_W  bytes accepted so far in current load

## Operation
- States: IDLE, LOAD, DONE, ERR.
- IDLE: o_rx_ready=0. On i_start: latch len=i_len, count=0, clear o_err. If len==0, go to DONE. If len>MAX_LEN, go to ERR. Otherwise go to LOAD.
- LOAD: o_rx_ready=1. On each handshake: o_wr_data<=i_rx_data, o_wr_addr<=count, o_wr_en<=1 for one cycle, count<=count+1. The handshake that makes count==len goes to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_count holds the final value until the next i_start.
- ERR: o_err<=1, then IDLE the next cycle.
- An i_start during LOAD is ignored.
- Bytes presented while not in LOAD are not accepted and are not written.
- Arithmetic: count is LEN_W bits unsigned. Because len<=MAX_LEN<2^LEN_W, count never wraps.
- Reset mid-load: all registers clear immediately and the partial load is abandoned. No done pulse is issued.

## Timing
- Reset values: state=IDLE. o_rx_ready, o_wr_en, o_busy, o_done, o_err = 0. o_wr_addr, o_wr_data, o_count = 0.
- i_start to o_rx_ready high: 1 cycle.
- Accepted byte to o_wr_en: 1 cycle (registered outputs). o_wr_addr and o_wr_data are valid in the o_wr_en cycle.
- Last write and o_done are in the same cycle. o_rx_ready drops in the cycle after the last handshake.
- len==0: o_done pulses 2 cycles after i_start, with no writes.
- o_busy is high in LOAD and DONE.
- Throughput: one byte per cycle, back-to-back.

## Configuration
- MATRIX_LOAD_TIMEOUT_EN defined:
  - A watchdog counts cycles in LOAD without a handshake and resets on each handshake.
  - On reaching TIMEOUT_CYCLES it goes to ERR, sets o_err, and emits no o_done.
- Not defined: no watchdog. LOAD waits indefinitely and TIMEOUT_CYCLES is unused.

## Structure
- Shared package matrix_pkg:
  - State enum (IDLE/LOAD/DONE/ERR).
  - MAX_LEN and the matrix-type length constants (2x2..5x5 forms).
- Sub-module load_watchdog: counter with clear/tick/expire. Instantiated only under MATRIX_LOAD_TIMEOUT_EN.

## Test plan
- Reset, i_start with i_len=5, then bytes 0x11..0x15 back-to-back -> five o_wr_en cycles at addr 0..4 with matching data; o_done one pulse coinciding with addr 4; o_count=5.
- i_len=50 with i_rx_valid toggling every other cycle -> 50 writes, addr 0..49, no gaps in address, single o_done.
- i_len=0 -> o_done 2 cycles after i_start, no o_wr_en, o_err=0.
- i_len=51 -> o_err=1, no writes, no done; next i_start with i_len=8 clears o_err and loads normally.
- Assert i_reset_n low after 3 of 8 bytes -> all outputs 0 immediately. After release, a new load with i_len=8 writes starting at addr 0.
- With MATRIX_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=16: stall after 2 of 5 bytes -> o_err=1 after 16 idle cycles, o_done never asserts.
